// File: rtl/clockdiv_nco.sv
// Multi-channel fractional clock generator: one phase accumulator (NCO) per channel,
// each with a runtime-programmable increment, a wrap tick and an MSB-derived clock.
module clockdiv_nco #(
  parameter int unsigned      NUM_CH    = 4,
  parameter int unsigned      ACC_W     = 24,
  parameter logic [ACC_W-1:0] INC_RESET = ACC_W'(24'h0754B6),
  localparam int unsigned     CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_src,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_imm,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  // Channel count widened by one bit so out-of-range selects can be detected for any NUM_CH.
  localparam logic [CH_W:0] NUM_CH_C = (CH_W+1)'(NUM_CH);

  logic w_ch_ok;
  logic w_cfg_ok;
  logic r_cfg_err;

  assign w_ch_ok  = ({1'b0, cfg_ch} < NUM_CH_C);
  assign w_cfg_ok = cfg_we & w_ch_ok;

  // Flag a config write aimed at a channel that does not exist.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we & ~w_ch_ok;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc_act;
    logic [ACC_W-1:0] r_inc_shd;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_out;

    logic [ACC_W:0]   w_sum;
    logic             w_hit;
    logic             w_wrap;
    logic [ACC_W-1:0] w_acc_nx;
    logic [ACC_W-1:0] w_inc_act_nx;
    logic [ACC_W-1:0] w_inc_shd_nx;
    logic             w_pending_nx;
    logic             w_tick_nx;
    logic             w_clk_out_nx;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc_act};
    assign w_hit = w_cfg_ok & (cfg_ch == CH_W'(gi));

    // Next-state: sync beats enable; a wrap or sync is the safe point to swap the increment.
    always_comb begin
      w_acc_nx     = r_acc;
      w_inc_act_nx = r_inc_act;
      w_inc_shd_nx = r_inc_shd;
      w_pending_nx = r_pending;
      w_tick_nx    = 1'b0;
      w_clk_out_nx = r_clk_out;
      w_wrap       = 1'b0;

      if (sync) begin
        w_acc_nx     = '0;
        w_clk_out_nx = 1'b0;
        w_wrap       = 1'b1;
      end else if (ch_en[gi]) begin
        w_acc_nx     = w_sum[ACC_W-1:0];
        w_tick_nx    = w_sum[ACC_W];
        w_clk_out_nx = w_sum[ACC_W-1];
        w_wrap       = w_sum[ACC_W];
      end

      if (w_wrap && r_pending) begin
        w_inc_act_nx = r_inc_shd;
        w_pending_nx = 1'b0;
      end

      // A write landing on a wrap/sync bypasses the shadow and takes effect right away.
      if (w_hit) begin
        if (cfg_imm || w_wrap) begin
          w_inc_act_nx = cfg_inc;
          w_pending_nx = 1'b0;
          if (!cfg_imm) begin
            w_inc_shd_nx = cfg_inc;
          end
        end else begin
          w_inc_shd_nx = cfg_inc;
          w_pending_nx = 1'b1;
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
        r_acc     <= '0;
        r_inc_act <= INC_RESET;
        r_inc_shd <= INC_RESET;
        r_pending <= 1'b0;
        r_tick    <= 1'b0;
        r_clk_out <= 1'b0;
      end else begin
        r_acc     <= w_acc_nx;
        r_inc_act <= w_inc_act_nx;
        r_inc_shd <= w_inc_shd_nx;
        r_pending <= w_pending_nx;
        r_tick    <= w_tick_nx;
        r_clk_out <= w_clk_out_nx;
      end
    end

    assign pending[gi] = r_pending;
    assign tick[gi]    = r_tick;
    assign clk_out[gi] = r_clk_out;
  end

endmodule

// File: tb/tb_clockdiv_nco.sv
// Directed bench for clockdiv_nco: main 4-channel instance plus a 3-channel instance
// whose select port can address a non-existent channel.
module tb_clockdiv_nco;

  logic        clk_src;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_inc;
  logic        cfg_imm;
  logic        cfg_err;
  logic [3:0]  pending;
  logic [3:0]  tick;
  logic [3:0]  clk_out;

  logic [2:0]  e_ch_en;
  logic        e_sync;
  logic        e_cfg_we;
  logic [1:0]  e_cfg_ch;
  logic [7:0]  e_cfg_inc;
  logic        e_cfg_imm;
  logic        e_cfg_err;
  logic [2:0]  e_pending;
  logic [2:0]  e_tick;
  logic [2:0]  e_clk_out;

  int ntot;
  int nbad;

  clockdiv_nco u_dut (
    .clk_src (clk_src),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_inc (cfg_inc),
    .cfg_imm (cfg_imm),
    .cfg_err (cfg_err),
    .pending (pending),
    .tick    (tick),
    .clk_out (clk_out)
  );

  clockdiv_nco #(
    .NUM_CH    (3),
    .ACC_W     (8),
    .INC_RESET (8'h40)
  ) u_dut3 (
    .clk_src (clk_src),
    .rst_n   (rst_n),
    .ch_en   (e_ch_en),
    .sync    (e_sync),
    .cfg_we  (e_cfg_we),
    .cfg_ch  (e_cfg_ch),
    .cfg_inc (e_cfg_inc),
    .cfg_imm (e_cfg_imm),
    .cfg_err (e_cfg_err),
    .pending (e_pending),
    .tick    (e_tick),
    .clk_out (e_clk_out)
  );

  initial clk_src = 1'b0;
  always #5 clk_src = ~clk_src;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and drop the single-cycle strobes.
  task automatic step();
    @(negedge clk_src);
    cfg_we   = 1'b0;
    sync     = 1'b0;
    e_cfg_we = 1'b0;
    e_sync   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_src);
    rst_n    = 1'b0;
    ch_en    = '0;
    sync     = 1'b0;
    cfg_we   = 1'b0;
    e_ch_en  = '0;
    e_sync   = 1'b0;
    e_cfg_we = 1'b0;
    @(negedge clk_src);
    rst_n    = 1'b1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [23:0] inc, input logic imm);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_inc = inc;
    cfg_imm = imm;
  endtask

  initial begin
    int cnt;
    int first;
    int last;
    int badp;
    int diff;
    int hi_cnt;
    logic [3:0] ev;

    ntot = 0; nbad = 0;
    rst_n = 1'b0; ch_en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_imm = 1'b0;
    e_ch_en = '0; e_sync = 1'b0; e_cfg_we = 1'b0; e_cfg_ch = '0; e_cfg_inc = '0; e_cfg_imm = 1'b0;

    // Reset state
    do_reset();
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_e_tick", 32'(e_tick), 32'h0);

    // T1: reset increment, 20000 cycles -> floor(20000*0x0754B6/2^24) = 572 ticks
    ch_en = 4'hF;
    cnt = 0; first = 0; last = 0; badp = 0; diff = 0;
    for (int k = 1; k <= 20000; k++) begin
      step();
      if (tick != {4{tick[0]}}) diff++;
      if (tick[0]) begin
        cnt++;
        if (first == 0) first = k;
        else if (!((k - last) inside {34, 35})) badp++;
        last = k;
      end
    end
    chk("t1_first_tick", 32'(first), 32'd35);
    chk("t1_count", 32'(cnt), 32'd572);
    chk("t1_bad_periods", 32'(badp), 32'd0);
    chk("t1_ch_agree", 32'(diff), 32'd0);

    // T2: immediate write ch1 inc=0x400000 -> tick every 4 cycles, clk 2 low / 2 high
    do_reset();
    ch_en = 4'hF;
    wr(2'd1, 24'h400000, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t2_tick", 32'(tick[1]), 32'(k >= 5 && (k % 4) == 1));
      chk("t2_clk", 32'(clk_out[1]), 32'(k >= 3 && ((k % 4) == 3 || (k % 4) == 0)));
      if (k == 1) chk("t2_pend", 32'(pending[1]), 32'h0);
    end

    // T3: inc=0x800000, deferred 0x200000 off-wrap then deferred 0x400000 on a wrap (bypass)
    do_reset();
    ch_en = 4'hF;
    wr(2'd0, 24'h800000, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      step();
      chk("t3_tick", 32'(tick[0]), 32'(k inside {3, 5, 7, 15, 23, 27, 31}));
      chk("t3_pend", 32'(pending[0]), 32'(k == 6));
      if (k == 5) wr(2'd0, 24'h200000, 1'b0);
      if (k == 22) wr(2'd0, 24'h400000, 1'b0);
    end

    // T4: ch0/ch2 same rate, different phase; sync aligns them and applies ch3's deferred write
    do_reset();
    ch_en = 4'hF;
    wr(2'd0, 24'h400000, 1'b1);
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k == 5) chk("t4_pre_ch0", 32'(tick), 32'h1);
      if (k == 6) chk("t4_pre_ch2", 32'(tick), 32'h4);
      if (k == 11) chk("t4_pend_ch3", 32'(pending), 32'h8);
      if (k == 12) chk("t4_pend_clr", 32'(pending), 32'h0);
      if (k >= 12) begin
        ev = ((k - 12) % 4 == 0 && k > 12) ? 4'b1101 : 4'b0000;
        chk("t4_tick", 32'(tick), 32'(ev));
        ev = ((k - 12) % 4 >= 2) ? 4'b1101 : 4'b0000;
        chk("t4_clk", 32'(clk_out), 32'(ev));
      end
      if (k == 1) wr(2'd2, 24'h400000, 1'b1);
      if (k == 2) wr(2'd3, 24'h400000, 1'b0);
      if (k == 11) sync = 1'b1;
    end

    // T5: pause ch1 mid-period for 10 cycles, resume keeps phase; then inc=0 freezes it
    do_reset();
    ch_en = 4'hF;
    wr(2'd1, 24'h400000, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k >= 7) begin
        chk("t5_tick", 32'(tick[1]), 32'(k inside {19, 23}));
        chk("t5_clk", 32'(clk_out[1]), 32'(k <= 18 || k inside {21, 22}));
      end
      if (k == 7) ch_en[1] = 1'b0;
      if (k == 17) ch_en[1] = 1'b1;
    end
    wr(2'd1, 24'h000000, 1'b1);
    step();
    chk("t5_frz_clk", 32'(clk_out[1]), 32'h1);
    cnt = 0; hi_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (tick[1]) cnt++;
      if (!clk_out[1]) hi_cnt++;
    end
    chk("t5_zero_ticks", 32'(cnt), 32'd0);
    chk("t5_clk_const", 32'(hi_cnt), 32'd0);

    // T6: async reset between edges clears outputs at once and restores INC_RESET
    do_reset();
    ch_en = 4'hF;
    wr(2'd1, 24'hC00000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) wr(2'd0, 24'h800000, 1'b0);
    end
    chk("t6_pre_tick", 32'(tick), 32'h2);
    chk("t6_pre_clk", 32'(clk_out), 32'h2);
    chk("t6_pre_pend", 32'(pending), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_tick", 32'(tick), 32'h0);
    chk("t6_async_clk", 32'(clk_out), 32'h0);
    chk("t6_async_pend", 32'(pending), 32'h0);
    @(negedge clk_src);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k <= 34 && tick != 4'h0) cnt++;
      if (k == 35) chk("t6_first_tick", 32'(tick), 32'hF);
    end
    chk("t6_early_ticks", 32'(cnt), 32'd0);
    chk("t6_pend_after", 32'(pending), 32'h0);

    // cfg_err: write to channel 3 of a 3-channel instance, then a valid write
    do_reset();
    e_ch_en = 3'b111;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("err_pulse", 32'(e_cfg_err), 32'(k == 2));
      chk("err_tick", 32'(e_tick), 32'((k % 4) == 0 ? 3'b111 : 3'b000));
      chk("err_clk", 32'(e_clk_out), 32'((k % 4) >= 2 ? 3'b111 : 3'b000));
      chk("err_pend", 32'(e_pending), 32'h0);
      chk("err_main", 32'(cfg_err), 32'h0);
      if (k == 1) begin
        e_cfg_we = 1'b1; e_cfg_ch = 2'd3; e_cfg_inc = 8'h00; e_cfg_imm = 1'b1;
      end
      if (k == 3) begin
        e_cfg_we = 1'b1; e_cfg_ch = 2'd2; e_cfg_inc = 8'h40; e_cfg_imm = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
